branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/bp_pkg.sv | 23 ++
 rtl/sat_counter.sv | 19 +
 rtl/branch_target_buffer.sv | 125 ++++++++++++
 tb/tb_branch_target_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch predictor defaults, counter constants and types
package bp_pkg;

   localparam int BP_ENTRIES = 16;
   localparam int BP_PC_W    = 16;
   localparam int BP_CNT_W   = 2;

   // Weakly-taken sits just at the MSB threshold; weakly-not-taken just below it.
   function automatic int ctr_weak_taken(input int cnt_w);
      return 1 << (cnt_w - 1);
   endfunction

   function automatic int ctr_weak_not_taken(input int cnt_w);
      return (1 << (cnt_w - 1)) - 1;
   endfunction

   typedef enum logic [1:0] {
      UPD_NONE,
      UPD_HIT,
      UPD_ALLOC
   } upd_kind_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - combinational saturating increment/decrement
module sat_counter #(
   parameter int W = 2
) (
   input  logic [W-1:0] cnt,
   input  logic         inc,
   output logic [W-1:0] cnt_nxt
);

   always_comb begin
      cnt_nxt = cnt;
      if (inc) begin
         if (cnt != '1) cnt_nxt = cnt + 1'b1;
      end else begin
         if (cnt != '0) cnt_nxt = cnt - 1'b1;
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - fully associative BTB with direction counters and statistics
module branch_target_buffer
   import bp_pkg::*;
#(
   parameter int ENTRIES = BP_ENTRIES,
   parameter int PC_W    = BP_PC_W,
   parameter int CNT_W   = BP_CNT_W,
   parameter int STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [PC_W-1:0]   lookup_pc,
   output logic              lookup_hit,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic [PC_W-1:0]   upd_pc_p1,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              upd_taken,
   output logic              redirect_valid,
   output logic [PC_W-1:0]   redirect_pc,
   output logic [STAT_W-1:0] hit_cnt,
   output logic [STAT_W-1:0] mispred_cnt
);

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(ctr_weak_taken(CNT_W));
   localparam logic [CNT_W-1:0] CTR_WNT = CNT_W'(ctr_weak_not_taken(CNT_W));

   logic [ENTRIES-1:0] valid_q;
   logic [PC_W-1:0]    tag_q [ENTRIES];
   logic [PC_W-1:0]    tgt_q [ENTRIES];
   logic [CNT_W-1:0]   ctr_q [ENTRIES];
   logic [IDX_W-1:0]   rr_q;

   logic               lk_hit, up_hit, inv_found;
   logic [IDX_W-1:0]   lk_idx, up_idx, inv_idx, vic_idx;
   logic               up_dir;
   logic [CNT_W-1:0]   ctr_nxt;
   upd_kind_e          kind;

   // Priority encoders: descending scan so the lowest matching index wins.
   always_comb begin
      lk_hit    = 1'b0;
      lk_idx    = '0;
      up_hit    = 1'b0;
      up_idx    = '0;
      inv_found = 1'b0;
      inv_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && tag_q[i] == lookup_pc) begin
            lk_hit = 1'b1;
            lk_idx = IDX_W'(i);
         end
         if (valid_q[i] && tag_q[i] == upd_pc) begin
            up_hit = 1'b1;
            up_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            inv_found = 1'b1;
            inv_idx   = IDX_W'(i);
         end
      end
   end

   assign vic_idx     = inv_found ? inv_idx : rr_q;
   assign lookup_hit  = lk_hit;
   assign pred_taken  = lk_hit & ctr_q[lk_idx][CNT_W-1];
   assign pred_target = lk_hit ? tgt_q[lk_idx] : '0;

   assign up_dir = up_hit & ctr_q[up_idx][CNT_W-1];

   // A predicted-taken hit that resolves taken still mispredicts if the target moved.
   assign redirect_valid = upd_valid &
                           ((up_dir != upd_taken) |
                            (up_dir & upd_taken & (tgt_q[up_idx] != upd_target)));
   assign redirect_pc    = redirect_valid ? (upd_taken ? upd_target : upd_pc_p1) : '0;

   sat_counter #(.W(CNT_W)) u_ctr (
      .cnt     (ctr_q[up_idx]),
      .inc     (upd_taken),
      .cnt_nxt (ctr_nxt)
   );

   always_comb begin
      kind = UPD_NONE;
      if (upd_valid && !flush) kind = up_hit ? UPD_HIT : UPD_ALLOC;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         rr_q        <= '0;
         hit_cnt     <= '0;
         mispred_cnt <= '0;
      end else begin
         if (redirect_valid && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
         if (kind == UPD_HIT && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
         if (flush) begin
            valid_q <= '0;
            rr_q    <= '0;
         end else if (kind == UPD_ALLOC) begin
            valid_q[vic_idx] <= 1'b1;
            if (!inv_found) rr_q <= rr_q + 1'b1;
         end
      end
   end

   // Payload arrays carry no reset; writes while in reset land in invalid entries.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENTRIES; i++) begin
         if (kind == UPD_ALLOC && vic_idx == IDX_W'(i)) begin
            tag_q[i] <= upd_pc;
            tgt_q[i] <= upd_target;
            ctr_q[i] <= upd_taken ? CTR_WT : CTR_WNT;
         end else if (kind == UPD_HIT && up_idx == IDX_W'(i)) begin
            ctr_q[i] <= ctr_nxt;
            if (upd_taken) tgt_q[i] <= upd_target;
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer
module tb_branch_target_buffer;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] lookup_pc = '0;
   logic        lookup_hit, pred_taken;
   logic [15:0] pred_target;
   logic        upd_valid = 1'b0;
   logic [15:0] upd_pc = '0, upd_pc_p1 = '0, upd_target = '0;
   logic        upd_taken = 1'b0;
   logic        redirect_valid;
   logic [15:0] redirect_pc, hit_cnt, mispred_cnt;

   always #5 clk = ~clk;

   branch_target_buffer dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .lookup_pc(lookup_pc), .lookup_hit(lookup_hit), .pred_taken(pred_taken),
      .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_pc_p1(upd_pc_p1), .upd_target(upd_target), .upd_taken(upd_taken),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
   );

   typedef struct {
      logic        hit, ptk;
      logic [15:0] ptg;
      logic        rv;
      logic [15:0] rpc, hc, mc;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("lookup_hit", 32'(lookup_hit), 32'(e.hit));
         chk("pred_taken", 32'(pred_taken), 32'(e.ptk));
         chk("pred_target", 32'(pred_target), 32'(e.ptg));
         chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
         chk("redirect_pc", 32'(redirect_pc), 32'(e.rpc));
         chk("hit_cnt", 32'(hit_cnt), 32'(e.hc));
         chk("mispred_cnt", 32'(mispred_cnt), 32'(e.mc));
      end
   end

   // Reference model: an associative table of entries, counters as plain integers.
   bit          m_v[N];
   logic [15:0] m_pc[N], m_tg[N];
   int          m_c[N];
   int          m_rr, m_hit, m_mis;

   function automatic int find(input logic [15:0] pc);
      for (int i = 0; i < N; i++) if (m_v[i] && m_pc[i] == pc) return i;
      return -1;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_rr = 0; m_hit = 0; m_mis = 0;
   endfunction

   task automatic step(input bit f, input logic [15:0] lpc, input bit uv,
                       input logic [15:0] upc, input bit ut, input logic [15:0] utg);
      exp_t e;
      int li, ui, v;
      bit pdir, rv;
      flush = f; lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
      upd_pc_p1 = upc + 16'd1; upd_taken = ut; upd_target = utg;
      li = find(lpc);
      e.hit = (li >= 0);
      e.ptk = (li >= 0) && (m_c[li] >= 2);
      e.ptg = (li >= 0) ? m_tg[li] : 16'h0;
      ui = find(upc);
      pdir = (ui >= 0) && (m_c[ui] >= 2);
      rv = uv && ((pdir != ut) || (pdir && ut && (ui >= 0) && m_tg[ui] != utg));
      e.rv = rv;
      e.rpc = rv ? (ut ? utg : upc + 16'd1) : 16'h0;
      e.hc = 16'(m_hit);
      e.mc = 16'(m_mis);
      sb.push_back(e);
      @(posedge clk);
      if (rv && m_mis < 65535) m_mis++;
      if (f) begin
         for (int i = 0; i < N; i++) m_v[i] = 0;
         m_rr = 0;
      end else if (uv) begin
         if (ui >= 0) begin
            if (m_hit < 65535) m_hit++;
            m_c[ui] = ut ? ((m_c[ui] < 3) ? m_c[ui] + 1 : 3) : ((m_c[ui] > 0) ? m_c[ui] - 1 : 0);
            if (ut) m_tg[ui] = utg;
         end else begin
            v = -1;
            for (int i = 0; i < N; i++) if (!m_v[i] && v < 0) v = i;
            if (v < 0) begin
               v = m_rr;
               m_rr = (m_rr + 1) % N;
            end
            m_v[v] = 1; m_pc[v] = upc; m_tg[v] = utg; m_c[v] = ut ? 2 : 1;
         end
      end
      #1;
   endtask

   initial begin
      logic [15:0] pc, tg, lpc;
      m_reset();
      #12;
      chk("rst_lookup_hit", 32'(lookup_hit), 0);
      chk("rst_pred_taken", 32'(pred_taken), 0);
      chk("rst_pred_target", 32'(pred_target), 0);
      chk("rst_redirect_valid", 32'(redirect_valid), 0);
      chk("rst_redirect_pc", 32'(redirect_pc), 0);
      chk("rst_hit_cnt", 32'(hit_cnt), 0);
      chk("rst_mispred_cnt", 32'(mispred_cnt), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      step(0, 16'h0010, 0, 16'h0000, 0, 16'h0000);
      step(0, 16'h0010, 1, 16'h0010, 1, 16'h0040);
      step(0, 16'h0010, 0, 16'h0000, 0, 16'h0000);
      repeat (3) step(0, 16'h0010, 1, 16'h0010, 0, 16'h0040);
      step(0, 16'h0010, 0, 16'h0000, 0, 16'h0000);
      repeat (2) step(0, 16'h0010, 1, 16'h0010, 1, 16'h0040);
      step(0, 16'h0010, 1, 16'h0010, 1, 16'h0080);
      step(0, 16'h0010, 0, 16'h0000, 0, 16'h0000);

      step(1, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      for (int i = 0; i < 17; i++) step(0, 16'h0000, 1, 16'h0100 + 16'(i), 1, 16'h0500 + 16'(i));
      step(0, 16'h0100, 0, 16'h0000, 0, 16'h0000);
      step(0, 16'h0101, 0, 16'h0000, 0, 16'h0000);

      step(1, 16'h0101, 1, 16'h0101, 1, 16'h0501);
      step(1, 16'h0000, 1, 16'h0777, 1, 16'h0010);
      step(0, 16'h0777, 0, 16'h0000, 0, 16'h0000);
      step(0, 16'h0101, 0, 16'h0000, 0, 16'h0000);

      for (int k = 0; k < 1500; k++) begin
         pc  = 16'h0200 + 16'($urandom_range(0, 23) * 4);
         tg  = 16'h1000 + 16'($urandom_range(0, 3) * 16);
         lpc = ($urandom_range(0, 3) == 0) ? pc : 16'h0200 + 16'($urandom_range(0, 23) * 4);
         step($urandom_range(0, 49) == 0, lpc, $urandom_range(0, 9) < 7, pc,
              $urandom_range(0, 1) == 1, tg);
      end

      step(0, 16'h0300, 1, 16'h0300, 1, 16'h0aa0);
      step(0, 16'h0300, 0, 16'h0000, 0, 16'h0000);
      lookup_pc = 16'h0300;
      upd_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("pre_async_hit", 32'(lookup_hit), 32'(find(16'h0300) >= 0));
      #2 rst_n = 1'b0;
      #1;
      chk("async_lookup_hit", 32'(lookup_hit), 0);
      chk("async_hit_cnt", 32'(hit_cnt), 0);
      chk("async_mispred_cnt", 32'(mispred_cnt), 0);
      m_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(0, 16'h0300, 0, 16'h0000, 0, 16'h0000);
      step(0, 16'h0300, 1, 16'h0300, 0, 16'h0aa0);
      step(0, 16'h0300, 0, 16'h0000, 0, 16'h0000);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      chk("scoreboard_drain", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
